// File: rtl/idelay_load_sequencer_if.sv
// Command channel from the calibration controller into the delay-load sequencer.
// The controller holds the master side; the sequencer is the slave.
interface idelay_load_sequencer_if #(
    parameter int CH_W = 3
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [CH_W-1:0] cmd_ch;
    logic [4:0]      cmd_dly;
    logic            cmd_last;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_dly,
        output cmd_last,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_dly,
        input  cmd_last,
        output cmd_ready
    );
endinterface

// File: rtl/idelay_load_sequencer.sv
// Stages per-channel tap values with one-cycle ld strobes and commits a batch
// with a single shared set strobe; mirrors committed values in a shadow table.
module idelay_load_sequencer #(
    parameter int         NUM_CH     = 8,
    parameter int         CH_W       = 3,
    parameter int         SET_GAP    = 1,
    parameter int         SETTLE     = 2,
    parameter logic [4:0] INIT_DELAY = 5'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    idelay_load_sequencer_if.slave cmd,
    output logic [4:0]            delay_o,
    output logic [NUM_CH-1:0]     ld_o,
    output logic                  set_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [5*NUM_CH-1:0]   shadow_o
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_SET,
        S_SETTLE
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              ready_q;
    logic              set_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [4:0]        delay_q;
    logic [NUM_CH-1:0] ld_q;
    logic [NUM_CH-1:0] pending_q;
    logic [4:0]        staged_q [NUM_CH];
    logic [4:0]        shadow_q [NUM_CH];

    logic [CH_W-1:0]   ch;
    logic [NUM_CH-1:0] ch_hot_d;
    logic              accept;

    assign ch     = cmd.cmd_ch;
    assign accept = cmd.cmd_valid & ready_q;

    // An out-of-range channel decodes to an all-zero vector, which doubles as the error flag.
    always_comb begin
        ch_hot_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_hot_d[i] = (32'(ch) == 32'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            set_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            delay_q   <= '0;
            ld_q      <= '0;
            pending_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= INIT_DELAY;
            end
        end else begin
            ld_q   <= '0;
            err_q  <= 1'b0;
            set_q  <= 1'b0;
            done_q <= 1'b0;

            if (accept) begin
                ld_q      <= ch_hot_d;
                err_q     <= ~|ch_hot_d;
                pending_q <= pending_q | ch_hot_d;
                if (|ch_hot_d) begin
                    delay_q <= cmd.cmd_dly;
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (ch_hot_d[i]) begin
                        staged_q[i] <= cmd.cmd_dly;
                    end
                end
            end

            case (state_q)
                S_IDLE, S_LOAD: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        if (cmd.cmd_last) begin
                            // The GAP count also spans the cycle carrying the last ld pulse.
                            state_q <= S_GAP;
                            cnt_q   <= 4'(SET_GAP);
                            ready_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q == 4'd0) begin
                        state_q   <= S_SET;
                        set_q     <= 1'b1;
                        pending_q <= '0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (pending_q[i]) begin
                                shadow_q[i] <= staged_q[i];
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_SET: begin
                    state_q <= S_SETTLE;
                    cnt_q   <= 4'(SETTLE - 1);
                    done_q  <= (SETTLE == 1);
                end
                S_SETTLE: begin
                    // The final SETTLE cycle is the done cycle; busy drops right after it.
                    if (cnt_q == 4'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q - 4'd1;
                        done_q <= (cnt_q == 4'd1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        shadow_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_o[5*i +: 5] = shadow_q[i];
        end
    end

    assign cmd.cmd_ready = ready_q;
    assign delay_o       = delay_q;
    assign ld_o          = ld_q;
    assign set_o         = set_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;
endmodule
